prio_encoder_irq: RTL and testbench

Parametrised, registered priority encoder with sticky request capture and a valid/ack handshake. It turns N request lines into a binary index, one request at a time, for interrupt/event dispatch. Compared with a plain combinational encoder, it latches requests until they are served and supports per-line masking. It also selects between edge and level capture and between two priority directions.

---
 rtl/prio_encoder_irq.sv | 151 +++++++++++++++
 tb/tb_prio_encoder_irq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_irq.sv
// prio_encoder_irq: registered priority encoder with sticky request capture,
// per-line masking and a valid/ack handshake. Requests are latched in a
// pending register until acknowledged. One index is presented at a time and
// is held without preemption until it is acked or its mask bit drops.
module prio_encoder_irq #(
  parameter int N         = 8,
  parameter int IDX_W     = (N > 1) ? $clog2(N) : 1,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit EDGE      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     din,
  input  logic [N-1:0]     mask,
  input  logic             ack,
  output logic [IDX_W-1:0] dout,
  output logic             valid,
  output logic [N-1:0]     pending
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // One-hot decode of an index. Bits at or above N cannot be set, so the
  // result is always a legal line vector.
  function automatic logic [N-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    oh = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  // Priority pick. The scan direction makes the last hit the winner, so only
  // indices below N can be returned.
  function automatic logic [IDX_W-1:0] select_idx(input logic [N-1:0] vec);
    logic [IDX_W-1:0] sel;
    sel = {IDX_W{1'b0}};
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) begin
          sel = IDX_W'(i);
        end else begin
          sel = sel;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) begin
          sel = IDX_W'(i);
        end else begin
          sel = sel;
        end
      end
    end
    return sel;
  endfunction

  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     din_q, din_d;
  logic [IDX_W-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;

  logic [N-1:0]     set_s;
  logic [N-1:0]     clr_s;
  logic [N-1:0]     elig_s;
  logic [N-1:0]     present_oh_s;

  // Capture/clear vectors, pending update and the presentation FSM.
  always_comb begin
    din_d        = din;
    present_oh_s = idx_onehot(dout_q);
    set_s        = EDGE ? (din & ~din_q) : din;
    elig_s       = pending_q & mask;

    // Only a real presentation can be acked; a stray ack clears nothing.
    if ((state_q == ST_PRESENT) && valid_q && ack) begin
      clr_s = present_oh_s;
    end else begin
      clr_s = {N{1'b0}};
    end

    // A new request on the bit being cleared wins over the clear.
    pending_d = (pending_q & ~clr_s) | set_s;

    state_d = state_q;
    dout_d  = dout_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (elig_s != {N{1'b0}}) begin
          dout_d  = select_idx(elig_s);
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (ack) begin
          // Ack beats withdraw when both occur together.
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if ((mask & present_oh_s) == {N{1'b0}}) begin
          // Masked while presented: withdraw but keep the pending bit.
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= {N{1'b0}};
      din_q     <= {N{1'b0}};
      dout_q    <= {IDX_W{1'b0}};
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
    end
  end

  assign dout    = dout_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_prio_encoder_irq.sv
// Testbench for prio_encoder_irq: three instances share the inputs
// (level/MSB-first, level/LSB-first, edge/MSB-first). A vector table drives
// the level instances. Hand-written sequences cover async reset and edge mode.
module tb_prio_encoder_irq;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [7:0] mask;
  logic       ack;

  logic [2:0] dout0, dout1, dout2;
  logic       v0, v1, v2;
  logic [7:0] p0, p1, p2;

  int checks = 0;
  int errors = 0;

  prio_encoder_irq #(.N(8), .LSB_FIRST(1'b0), .EDGE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .mask(mask), .ack(ack),
    .dout(dout0), .valid(v0), .pending(p0));

  prio_encoder_irq #(.N(8), .LSB_FIRST(1'b1), .EDGE(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .mask(mask), .ack(ack),
    .dout(dout1), .valid(v1), .pending(p1));

  prio_encoder_irq #(.N(8), .LSB_FIRST(1'b0), .EDGE(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .mask(mask), .ack(ack),
    .dout(dout2), .valid(v2), .pending(p2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] mask;
    logic       ack;
    logic       v0;
    logic [2:0] d0;
    logic [7:0] p0;
    logic       v1;
    logic [2:0] d1;
    logic [7:0] p1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] di, input logic [7:0] m, input logic a,
                              input logic ev0, input logic [2:0] ed0, input logic [7:0] ep0,
                              input logic ev1, input logic [2:0] ed1, input logic [7:0] ep1);
    vec_t r;
    r.din = di; r.mask = m; r.ack = a;
    r.v0 = ev0; r.d0 = ed0; r.p0 = ep0;
    r.v1 = ev1; r.d1 = ed1; r.p1 = ep1;
    return r;
  endfunction

  function automatic vec_t mks(input logic [7:0] di, input logic [7:0] m, input logic a,
                               input logic ev, input logic [2:0] ed, input logic [7:0] ep);
    return mk(di, m, a, ev, ed, ep, ev, ed, ep);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int  npres;
    bit  found;

    rst_n = 1'b0; din = 8'h00; mask = 8'hFF; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a presentation.
    din = 8'h04;
    @(posedge clk); #1;
    din = 8'h00;
    @(posedge clk); #1;
    chk("pre_rst_valid", 0, int'(v0), 1);
    chk("pre_rst_dout", 0, int'(dout0), 2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 0, int'(v0), 0);
    chk("async_rst_dout", 0, int'(dout0), 0);
    chk("async_rst_pending", 0, int'(p0), 0);
    chk("async_rst_valid_edge", 0, int'(v2), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", 0, int'(v0), 0);
    chk("post_rst_pending", 0, int'(p0), 0);

    // Single request.
    tbl.push_back(mks(8'h04, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h04));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b0, 1'b1, 3'd2, 8'h04));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h00));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b0, 1'b0, 3'd2, 8'h00));
    // Priority order: dut0 serves 7 then 0, dut1 serves 0 then 7.
    tbl.push_back(mks(8'h81, 8'hFF, 1'b0, 1'b0, 3'd2, 8'h81));
    tbl.push_back(mk (8'h00, 8'hFF, 1'b0, 1'b1, 3'd7, 8'h81, 1'b1, 3'd0, 8'h81));
    tbl.push_back(mk (8'h00, 8'hFF, 1'b1, 1'b0, 3'd7, 8'h01, 1'b0, 3'd0, 8'h80));
    tbl.push_back(mk (8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 3'd7, 8'h80));
    tbl.push_back(mk (8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 8'h00));
    tbl.push_back(mk (8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 8'h00));
    // No preemption: 3 is held while 6 arrives.
    tbl.push_back(mk (8'h08, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0, 3'd7, 8'h08));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08));
    tbl.push_back(mks(8'h40, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h48));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h48));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h40));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b0, 1'b1, 3'd6, 8'h40));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b1, 1'b0, 3'd6, 8'h00));
    // Set wins over clear with din[3] held through the ack.
    tbl.push_back(mks(8'h08, 8'hFF, 1'b0, 1'b0, 3'd6, 8'h08));
    tbl.push_back(mks(8'h08, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08));
    tbl.push_back(mks(8'h08, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h08));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00));
    // Masking and withdraw.
    tbl.push_back(mks(8'h20, 8'hDF, 1'b0, 1'b0, 3'd3, 8'h20));
    tbl.push_back(mks(8'h00, 8'hDF, 1'b0, 1'b0, 3'd3, 8'h20));
    tbl.push_back(mks(8'h00, 8'hDF, 1'b0, 1'b0, 3'd3, 8'h20));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20));
    tbl.push_back(mks(8'h00, 8'hDF, 1'b0, 1'b0, 3'd5, 8'h20));
    tbl.push_back(mks(8'h00, 8'hDF, 1'b0, 1'b0, 3'd5, 8'h20));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b1, 1'b0, 3'd5, 8'h00));
    // Ack while idle is ignored.
    tbl.push_back(mks(8'h00, 8'hFF, 1'b1, 1'b0, 3'd5, 8'h00));
    // Ack and withdraw together: ack wins, bit cleared.
    tbl.push_back(mks(8'h20, 8'hFF, 1'b0, 1'b0, 3'd5, 8'h20));
    tbl.push_back(mks(8'h00, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20));
    tbl.push_back(mks(8'h00, 8'hDF, 1'b1, 1'b0, 3'd5, 8'h00));

    foreach (tbl[i]) begin
      din  = tbl[i].din;
      mask = tbl[i].mask;
      ack  = tbl[i].ack;
      @(posedge clk); #1;
      chk("msb_valid",   i, int'(v0),    int'(tbl[i].v0));
      chk("msb_dout",    i, int'(dout0), int'(tbl[i].d0));
      chk("msb_pending", i, int'(p0),    int'(tbl[i].p0));
      chk("lsb_valid",   i, int'(v1),    int'(tbl[i].v1));
      chk("lsb_dout",    i, int'(dout1), int'(tbl[i].d1));
      chk("lsb_pending", i, int'(p1),    int'(tbl[i].p1));
    end

    // Edge mode: a held request is presented exactly once.
    din = 8'h00; mask = 8'hFF; ack = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    din = 8'h02;
    npres = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (v2) begin
        npres++;
        chk("edge_dout", c, int'(dout2), 1);
        ack = 1'b1;
      end else begin
        ack = 1'b0;
      end
    end
    ack = 1'b0;
    chk("edge_presentations", 0, npres, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("edge_no_repeat_valid", 0, int'(v2), 0);
    chk("edge_no_repeat_pending", 0, int'(p2), 0);

    // Drop and re-raise: second presentation, bounded wait.
    din = 8'h00;
    @(posedge clk); #1;
    din = 8'h02;
    found = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (v2 && !found) begin
        found = 1'b1;
        chk("edge_second_dout", c, int'(dout2), 1);
      end
    end
    chk("edge_second_seen", 0, int'(found), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
